// File: rtl/stall_flush_unit.sv
// stall_flush_unit: stall and flush control for the 5-stage core.
// Covers load-use, taken branches, R15 writes and multi-cycle multiplies.
module stall_flush_unit #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       PCWrPendF,
  output logic       MulBusy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Counter preload: cycles left after the start cycle and the final cycle.
  localparam logic [3:0] CNT_INIT =
    (MUL_CYCLES > 2) ? 4'(MUL_CYCLES - 2) : 4'd0;

  mul_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pc_e_q, pc_e_d;
  logic       pc_m_q, pc_m_d;
  logic       pc_w_q, pc_w_d;

  logic mul_busy;
  logic ldr_stall;
  logic src_hit;
  logic pc_pend;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;

  // Hazard detection and raw stall/flush terms.
  always_comb begin
    mul_busy  = 1'b0;
    src_hit   = 1'b0;
    ldr_stall = 1'b0;
    pc_pend   = 1'b0;
    unique case (state_q)
      IDLE: mul_busy = MulStartE;
      BUSY: mul_busy = (cnt_q != 4'd0);
      default: mul_busy = 1'b0;
    endcase
    src_hit   = (WA3E == RA1D) | (WA3E == RA2D);
    ldr_stall = RegWriteE & MemtoRegE & ~mul_busy & src_hit;
    pc_pend   = PCSrcD | pc_e_q | pc_m_q;
    stall_f   = ldr_stall | pc_pend | mul_busy;
    stall_d   = ldr_stall | mul_busy;
    stall_e   = mul_busy;
    flush_d   = ~stall_d & (pc_pend | pc_w_q | BranchTakenE);
    flush_e   = ~mul_busy & (ldr_stall | BranchTakenE);
    flush_m   = mul_busy;
  end

  // Outputs are held low for as long as reset is asserted.
  always_comb begin
    StallF    = reset_n & stall_f;
    StallD    = reset_n & stall_d;
    StallE    = reset_n & stall_e;
    FlushD    = reset_n & flush_d;
    FlushE    = reset_n & flush_e;
    FlushM    = reset_n & flush_m;
    PCWrPendF = reset_n & pc_pend;
    MulBusy   = reset_n & mul_busy;
  end

  // Next state of the PC-write tracking bits as the write moves down.
  always_comb begin
    pc_e_d = PCSrcD;
    pc_m_d = pc_e_q;
    pc_w_d = pc_m_q;
    if (flush_e) begin
      pc_e_d = 1'b0;
    end else if (stall_e) begin
      pc_e_d = pc_e_q;
    end
    if (stall_e) begin
      pc_m_d = 1'b0;
    end
  end

  // Multiply occupancy FSM; a new start is ignored while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MulStartE) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pc_e_q  <= 1'b0;
      pc_m_q  <= 1'b0;
      pc_w_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_e_q  <= pc_e_d;
      pc_m_q  <= pc_m_d;
      pc_w_q  <= pc_w_d;
    end
  end

endmodule

// File: tb/tb_stall_flush_unit.sv
// tb_stall_flush_unit: directed vectors for stall_flush_unit.
// Output word order: StallF StallD StallE FlushD FlushE FlushM PCWrPendF MulBusy.
module tb_stall_flush_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] RA1D, RA2D, WA3E;
  logic       RegWriteE, MemtoRegE, PCSrcD;
  logic       BranchTakenE, MulStartE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       PCWrPendF, MulBusy;

  int checks = 0;
  int errors = 0;

  stall_flush_unit #(.MUL_CYCLES(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3E         (WA3E),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .BranchTakenE (BranchTakenE),
    .MulStartE    (MulStartE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .PCWrPendF    (PCWrPendF),
    .MulBusy      (MulBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare at negedge, advance past posedge.
  task automatic vec(input string tag,
                     input logic rst_n,
                     input logic [3:0] ra1,
                     input logic [3:0] ra2,
                     input logic [3:0] wa3,
                     input logic rw,
                     input logic m2r,
                     input logic pcs,
                     input logic br,
                     input logic mul,
                     input logic [7:0] exp);
    reset_n      = rst_n;
    RA1D         = ra1;
    RA2D         = ra2;
    WA3E         = wa3;
    RegWriteE    = rw;
    MemtoRegE    = m2r;
    PCSrcD       = pcs;
    BranchTakenE = br;
    MulStartE    = mul;
    @(negedge clk);
    check(tag, {StallF, StallD, StallE, FlushD,
                FlushE, FlushM, PCWrPendF, MulBusy}, exp);
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LDU  = 8'b1100_1000;
  localparam logic [7:0] BRT  = 8'b0001_1000;
  localparam logic [7:0] PCW  = 8'b1001_0010;
  localparam logic [7:0] PCF  = 8'b0001_0000;
  localparam logic [7:0] PLU  = 8'b1100_1010;
  localparam logic [7:0] MUL  = 8'b1110_0101;

  initial begin
    #1;
    // tag rst ra1 ra2 wa3 rw m2r pcs br mul exp
    vec("rst0",  0, 0, 0, 0, 0, 0, 1, 0, 1, NONE);
    vec("rst1",  0, 0, 0, 0, 0, 0, 1, 0, 1, NONE);
    vec("idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("ldu",   1, 1, 3, 3, 1, 1, 0, 0, 0, LDU);
    vec("ldu+1", 1, 1, 3, 3, 1, 0, 0, 0, 0, NONE);
    vec("ldnom", 1, 4, 5, 3, 1, 1, 0, 0, 0, NONE);
    vec("ldnrw", 1, 3, 5, 3, 0, 1, 0, 0, 0, NONE);
    vec("ldr15", 1, 15, 2, 15, 1, 1, 0, 0, 0, LDU);

    vec("br",    1, 0, 0, 0, 0, 0, 0, 1, 0, BRT);
    vec("br+1",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("pcw0",  1, 0, 0, 0, 0, 0, 1, 0, 0, PCW);
    vec("pcw1",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCW);
    vec("pcw2",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCW);
    vec("pcw3",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCF);
    vec("pcw4",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("pld0",  1, 3, 0, 3, 1, 1, 1, 0, 0, PLU);
    vec("pld1",  1, 3, 0, 3, 1, 0, 1, 0, 0, PCW);
    vec("pld2",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCW);
    vec("pld3",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCW);
    vec("pld4",  1, 0, 0, 0, 0, 0, 0, 0, 0, PCF);
    vec("pld5",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("mul0",  1, 5, 0, 5, 1, 1, 0, 0, 1, MUL);
    vec("mul1",  1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mul2",  1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mul3",  1, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    vec("mul4",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("mr0",   1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mrrst", 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    vec("mrrel", 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    vec("mra0",  1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mra1",  1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mra2",  1, 0, 0, 0, 0, 0, 0, 0, 1, MUL);
    vec("mra3",  1, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    vec("mra4",  1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    vec("pr0",   1, 0, 0, 0, 0, 0, 1, 0, 0, PCW);
    vec("prrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    vec("prrel", 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    vec("prrl2", 1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
